// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode helpers for seq_alu.
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_OR   = 5'b00010;
  localparam logic [4:0] ALU_XOR  = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_BEQ  = 5'b00111;
  localparam logic [4:0] ALU_BNE  = 5'b01000;
  localparam logic [4:0] ALU_BLT  = 5'b01001;
  localparam logic [4:0] ALU_BGE  = 5'b01010;
  localparam logic [4:0] ALU_BLTU = 5'b01011;
  localparam logic [4:0] ALU_BGEU = 5'b01100;
  localparam logic [4:0] ALU_SRA  = 5'b01101;
  localparam logic [4:0] ALU_SLT  = 5'b01110;
  localparam logic [4:0] ALU_SLTU = 5'b01111;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_DIVU = 5'b10001;
  localparam logic [4:0] ALU_REMU = 5'b10010;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic logic is_branch(input logic [4:0] op);
    return (op >= ALU_BEQ) && (op <= ALU_BGEU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Only instantiated when SEQ_ALU_MULDIV_EN is defined.
module seq_alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  // acc: product / remainder; opa: multiplicand / quotient; opb: multiplier / divisor
  logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d, div_q, div_d, rem_q, rem_d;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;

  always_comb begin
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    div_d    = div_q;
    rem_d    = rem_q;
    rem_sh   = {acc_q, opa_q[XLEN-1]};
    diff     = rem_sh - {1'b0, opb_q};
    ge       = (rem_sh >= {1'b0, opb_q});
    if (start_i) begin
      acc_d    = '0;
      opa_d    = a_i;
      opb_d    = b_i;
      cnt_d    = CntW'(XLEN);
      active_d = 1'b1;
      div_d    = (op_i != ALU_MUL);
      rem_d    = (op_i == ALU_REMU);
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
        if (div_q) begin
          // A zero divisor always subtracts, giving all-ones quotient and remainder = dividend
          acc_d = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          opa_d = {opa_q[XLEN-2:0], ge};
        end else begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
    end
  end

  assign done_o   = active_q && (cnt_q == '0);
  assign result_o = (div_q && !rem_q) ? opa_q : acc_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: registered single-cycle ops plus optional iterative
// MUL/DIVU/REMU built only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_bcond,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, simple_res, md_result;
  logic            bcond_q, bcond_d, simple_bcond;
  logic            accept, is_mul_op, is_div_op, md_done;
  logic [SHAMT_W-1:0] shamt;

  assign shamt  = alu_in_2[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;

`ifdef SEQ_ALU_MULDIV_EN
  assign is_mul_op = (alu_op == ALU_MUL);
  assign is_div_op = (alu_op == ALU_DIVU) || (alu_op == ALU_REMU);

  seq_alu_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (accept && (is_mul_op || is_div_op)),
    .op_i     (alu_op),
    .a_i      (alu_in_1),
    .b_i      (alu_in_2),
    .done_o   (md_done),
    .result_o (md_result)
  );
`else
  assign is_mul_op = 1'b0;
  assign is_div_op = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    simple_res   = '0;
    simple_bcond = 1'b0;
    case (alu_op)
      ALU_ADD:  simple_res = alu_in_1 + alu_in_2;
      ALU_AND:  simple_res = alu_in_1 & alu_in_2;
      ALU_OR:   simple_res = alu_in_1 | alu_in_2;
      ALU_XOR:  simple_res = alu_in_1 ^ alu_in_2;
      ALU_SLL:  simple_res = alu_in_1 << shamt;
      ALU_SRL:  simple_res = alu_in_1 >> shamt;
      ALU_SUB:  simple_res = alu_in_1 - alu_in_2;
      ALU_SRA:  simple_res = $unsigned($signed(alu_in_1) >>> shamt);
      ALU_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
      ALU_SLTU: simple_res = {{(XLEN-1){1'b0}}, alu_in_1 < alu_in_2};
      ALU_BEQ:  simple_bcond = (alu_in_1 == alu_in_2);
      ALU_BNE:  simple_bcond = (alu_in_1 != alu_in_2);
      ALU_BLT:  simple_bcond = ($signed(alu_in_1) < $signed(alu_in_2));
      ALU_BGE:  simple_bcond = ($signed(alu_in_1) >= $signed(alu_in_2));
      ALU_BLTU: simple_bcond = (alu_in_1 < alu_in_2);
      ALU_BGEU: simple_bcond = (alu_in_1 >= alu_in_2);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_mul_op)      state_d = StMul;
          else if (is_div_op) state_d = StDiv;
          else                state_d = StDone;
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: if (md_done) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    busy      = (state_q == StMul) || (state_q == StDiv);
  end

  always_comb begin
    result_d = result_q;
    bcond_d  = bcond_q;
    if (accept && !is_mul_op && !is_div_op) begin
      result_d = simple_res;
      bcond_d  = simple_bcond;
    end else if (md_done) begin
      result_d = md_result;
      bcond_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      bcond_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      bcond_q  <= bcond_d;
    end
  end

  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu; expectations adapt to SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, alu_bcond, busy;
  logic [4:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, alu_result;
  int          vectors = 0;
  int          miscompares = 0;

`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif
  localparam int LongLat = MdEn ? 33 : 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .alu_in_1   (alu_in_1),
    .alu_in_2   (alu_in_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    alu_op = op; alu_in_1 = a; alu_in_2 = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_long(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
    int   k = 0;
    logic hold_ok = 1'b1;
    send(op, a, b);
    in_valid = 1'b0;
    alu_op   = ALU_ADD;
    alu_in_1 = $urandom;
    alu_in_2 = $urandom;
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, MdEn});
    while (!out_valid && k < 100) begin
      if (!busy || in_ready) hold_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, LongLat);
    check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    check({tag, "_res"}, alu_result, MdEn ? exp_res : 32'd0);
    check({tag, "_bcond"}, {31'd0, alu_bcond}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = ALU_ADD; alu_in_1 = '0; alu_in_2 = '0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_res",   alu_result, 32'd0);
    check("rst_bcond", {31'd0, alu_bcond}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);

    send(ALU_ADD, 32'hFFFF_FFFF, 32'd1);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_res",   alu_result, 32'h0000_0000);
    check("add_bcond", {31'd0, alu_bcond}, 32'd0);
    check("add_ready", {31'd0, in_ready}, 32'd1);
    send(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check("xor_valid", {31'd0, out_valid}, 32'd1);
    check("xor_res",   alu_result, 32'h0FF0_0FF0);
    send(ALU_BLT, 32'hFFFF_FFFF, 32'd1);
    check("blt_res",   alu_result, 32'd0);
    check("blt_bcond", {31'd0, alu_bcond}, 32'd1);
    send(ALU_BLTU, 32'hFFFF_FFFF, 32'd1);
    check("bltu_bcond", {31'd0, alu_bcond}, 32'd0);
    send(ALU_BGE, 32'd5, 32'd5);
    check("bge_bcond", {31'd0, alu_bcond}, 32'd1);
    send(ALU_SRA, 32'h8000_0000, 32'd4);
    check("sra_res",   alu_result, 32'hF800_0000);
    check("sra_bcond", {31'd0, alu_bcond}, 32'd0);
    send(ALU_SRL, 32'h8000_0000, 32'd4);
    check("srl_res", alu_result, 32'h0800_0000);
    send(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    check("slt_res", alu_result, 32'd1);
    send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    check("sltu_res", alu_result, 32'd0);
    send(ALU_SUB, 32'd3, 32'd5);
    check("sub_res", alu_result, 32'hFFFF_FFFE);
    send(ALU_SLL, 32'd1, 32'h0000_0021);
    check("sll_res", alu_result, 32'd2);
    send(ALU_BNE, 32'd1, 32'd2);
    check("bne_bcond", {31'd0, alu_bcond}, 32'd1);
    send(5'b11111, 32'd5, 32'd6);
    check("unk_valid", {31'd0, out_valid}, 32'd1);
    check("unk_res",   alu_result, 32'd0);
    check("unk_bcond", {31'd0, alu_bcond}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_ready", {31'd0, in_ready}, 32'd1);

    run_long("mul",     ALU_MUL,  32'h0001_0003, 32'h0000_0005, 32'h0005_000F);
    run_long("mul_big", ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_long("divu",    ALU_DIVU, 32'd100, 32'd7, 32'd14);
    run_long("remu",    ALU_REMU, 32'd100, 32'd7, 32'd2);
    run_long("divu_z",  ALU_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    run_long("remu_z",  ALU_REMU, 32'd9, 32'd0, 32'd9);
    in_valid = 1'b0;
    @(negedge clk);

    // Consumer stall with a pending upstream request held
    out_ready = 1'b0;
    send(ALU_ADD, 32'd7, 32'd8);
    alu_op = ALU_SUB; alu_in_1 = 32'd1; alu_in_2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_res",   alu_result, 32'd15);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);

    send(ALU_DIVU, 32'd1000, 32'd3);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_busy",  {31'd0, busy}, 32'd0);
    check("mrst_res",   alu_result, 32'd0);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    send(ALU_ADD, 32'd2, 32'd3);
    check("post_valid", {31'd0, out_valid}, 32'd1);
    check("post_res",   alu_result, 32'd5);
    in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU. Serves the multi-cycle core's execute stage.
- Keeps the existing 5-bit opcode map for ADD..BGE and adds signed/unsigned compares, SRA, SLT/SLTU and iterative MUL/DIVU/REMU.
- Every result is registered. Operations complete in 1 cycle (simple ops) or XLEN+1 cycles (mul/div) behind a valid/ready interface.

Parameters:
- XLEN, 32, operand/result width; any value >= 8.
- SHAMT_W, $clog2(XLEN), shift-amount bits taken from alu_in_2[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- alu_op  in  5  opcode.
- alu_in_1  in  XLEN  operand A.
- alu_in_2  in  XLEN  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- alu_result  out  XLEN  registered result.
- alu_bcond  out  1  registered branch condition.
- busy  out  1  iterative op in progress (state MUL or DIV).

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, alu_result=0, alu_bcond=0, busy=0, internal counters/accumulators=0. Reset mid-operation discards the op with no output.
- Opcodes:
  - 00000 ADD, 00001 AND, 00010 OR, 00011 XOR, 00100 SLL, 00101 SRL, 00110 SUB.
  - 00111 BEQ, 01000 BNE, 01001 BLT (signed), 01010 BGE (signed), 01011 BLTU, 01100 BGEU.
  - 01101 SRA, 01110 SLT, 01111 SLTU.
  - 10000 MUL (low XLEN of product), 10001 DIVU, 10010 REMU.
  - All other values are unknown ops.
- Branch ops: alu_result=0, alu_bcond=compare. Non-branch ops: alu_bcond=0. Unknown op: result 0, bcond 0, 1-cycle latency.
- Arithmetic wraps modulo 2^XLEN. SLT/SLTU return 1 or 0, zero-extended.
- State machine IDLE/MUL/DIV/DONE:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept (in_valid & in_ready) of a simple op: result registered, DONE next cycle, out_valid=1. Latency 1.
  - Accept of MUL: operands latched, state MUL, counter=XLEN. One shift-add per cycle; DONE when counter reaches 0. Latency XLEN+1.
  - Accept of DIVU/REMU: state DIV, restoring division, one quotient bit per cycle. Latency XLEN+1.
  - DONE: out_valid=1; alu_result and alu_bcond held stable until out_ready.
  - DONE & out_ready & no new accept -> IDLE, out_valid=0.
  - DONE & out_ready & accept of a new op -> back-to-back, no bubble for simple ops.
- Divide by zero: DIVU result all-ones, REMU result = alu_in_1. Same latency as a normal divide.
- Operands and opcode are sampled only on accept. Input changes during MUL/DIV are ignored.
- in_valid while busy: not accepted (in_ready=0). Upstream holds the request.
- out_ready while not out_valid: no effect.

Optional Feature:
- Macro SEQ_ALU_MULDIV_EN.
- Defined: MUL/DIVU/REMU implemented as above, and busy can assert.
- Undefined: the MUL/DIV states and datapath are not built. Opcodes 10000-10010 behave as unknown ops (result 0, 1-cycle), and busy is tied 0.

Decomposition:
- Package alu_pkg: 5-bit opcode localparams (ALU_ADD..ALU_REMU), 2-bit state encoding, and an is_branch(op) constant function.
- One sub-module, seq_alu_muldiv:
  - Iterative shift-add multiplier / restoring divider with start, op, operands, done and result.
  - Compiled only under SEQ_ALU_MULDIV_EN.
- Top level keeps the handshake FSM and the single-cycle datapath.

Test Plan:
- ADD 0xFFFFFFFF+1, out_ready=1 -> out_valid one cycle after accept, result 0x00000000, bcond 0. Back-to-back XOR next cycle is accepted without a bubble.
- BLT 0xFFFFFFFF vs 1 -> bcond 1; BLTU same operands -> bcond 0; SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0x0001_0003 x 0x0000_0005 (MULDIV_EN) -> 0x0005_000F after 33 cycles. busy high throughout, in_ready 0.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- Result ready with out_ready held 0 for 5 cycles -> out_valid and result stable, in_ready 0; release -> consumed, IDLE.
- reset_n pulsed low mid-DIV -> immediately out_valid=0, busy=0, result 0. Next ADD 2+3 -> 5 normally.
